// File: rtl/dmem_arbiter.sv
// Arbiter for a single-port synchronous data memory shared by the CPU memory stage and a DMA port.
// The CPU wins by default, and a DMA request that has lost STARVE_MAX cycles in a row is forced through.
module dmem_arbiter #(
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [31:0]   i_cpu_addr,
  input  logic [31:0]   i_cpu_wdata,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_dma_req,
  input  logic          i_dma_we,
  input  logic [31:0]   i_dma_addr,
  input  logic [31:0]   i_dma_wdata,
  output logic          o_dma_gnt,
  output logic          o_dma_rvalid,
  output logic [31:0]   o_dma_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_t;

  localparam logic [AW-1:0] ADDR_MASK = AW'(DEPTH - 1);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  state_t      r_state;
  logic [3:0]  r_starve_cnt;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dma_rdata;
  logic        r_dma_rvalid;

  logic w_idle, w_force_dma, w_cpu_win, w_dma_win;
  logic w_unused;

  assign w_idle      = (r_state == IDLE);
  assign w_force_dma = i_dma_req && (r_starve_cnt == STARVE_LIM);
  assign w_cpu_win   = w_idle && i_cpu_req && !w_force_dma;
  assign w_dma_win   = w_idle && i_dma_req && !w_cpu_win;

  // Byte-offset and upper address bits are dropped: word access, wrapping modulo DEPTH*4.
  assign w_unused = &{1'b0, i_cpu_addr[31:AW+2], i_cpu_addr[1:0],
                      i_dma_addr[31:AW+2], i_dma_addr[1:0]};

  // All combinational outputs are forced low while reset is asserted.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_dma_gnt   = 1'b0;
    o_cpu_stall = 1'b0;
    if (rst) begin
      if (w_cpu_win) begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_cpu_we;
        o_mem_addr  = i_cpu_addr[AW+1:2] & ADDR_MASK;
        o_mem_wdata = i_cpu_wdata;
      end else if (w_dma_win) begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_dma_we;
        o_mem_addr  = i_dma_addr[AW+1:2] & ADDR_MASK;
        o_mem_wdata = i_dma_wdata;
        o_dma_gnt   = 1'b1;
      end
      case (r_state)
        IDLE:    o_cpu_stall = i_cpu_req && !(w_cpu_win && i_cpu_we);
        DMA_RD:  o_cpu_stall = i_cpu_req;
        default: o_cpu_stall = 1'b0;
      endcase
    end
  end

  // Return cycles pass memory data straight through; otherwise the last captured value is held.
  assign o_cpu_rdata  = (r_state == CPU_RD) ? i_mem_rdata : r_cpu_rdata;
  assign o_dma_rdata  = (r_state == DMA_RD) ? i_mem_rdata : r_dma_rdata;
  assign o_dma_rvalid = r_dma_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_dma_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cpu_win && !i_cpu_we) begin
            r_state <= CPU_RD;
          end else if (w_dma_win && !i_dma_we) begin
            r_state      <= DMA_RD;
            r_dma_rvalid <= 1'b1;
          end
        end
        CPU_RD: begin
          r_cpu_rdata <= i_mem_rdata;
          r_state     <= IDLE;
        end
        DMA_RD: begin
          r_dma_rdata <= i_mem_rdata;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Busy read-return cycles also count as lost cycles for a waiting DMA.
      if (w_dma_win || !i_dma_req)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != STARVE_LIM)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural single-port memory attached.
// Load data expectations are queued at request time and popped when the read returns.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [7:0]  mem_addr;

  logic [31:0] mem [256];
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  int n_cmp = 0, n_err = 0;
  logic cpu_pend = 0, dma_pend = 0;

  dmem_arbiter #(.DEPTH(256), .AW(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  // Return monitor: a read granted in one cycle must return in the next.
  always @(negedge clk) begin
    if (!rst) begin
      cpu_pend = 0;
      dma_pend = 0;
    end else begin
      chk("dma_rvalid_timing", {31'd0, dma_rvalid}, {31'd0, dma_pend});
      if (dma_pend) begin
        chk("dma_q_nonempty", {31'd0, dma_q.size() != 0}, 32'd1);
        if (dma_q.size() != 0) chk("dma_rdata", dma_rdata, dma_q.pop_front());
      end
      if (cpu_pend) begin
        chk("cpu_stall_ret", {31'd0, cpu_stall}, 32'd0);
        chk("cpu_q_nonempty", {31'd0, cpu_q.size() != 0}, 32'd1);
        if (cpu_q.size() != 0) chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      dma_pend = dma_gnt && !dma_we;
      cpu_pend = mem_en && !mem_we && !dma_gnt;
    end
  end

  initial begin
    int cnt;
    logic exp_dma;

    // Reset: combinational outputs forced low even with a request present
    set_cpu(1, 1, 32'h44, 32'h1);
    smp();
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    set_cpu(0, 0, 0, 0);
    cyc(); rst = 1'b1;
    cyc();

    // CPU store then load
    set_cpu(1, 1, 32'h10, 32'hDEADBEEF);
    smp();
    chk("st_stall", {31'd0, cpu_stall}, 32'd0);
    chk("st_mem_addr", {24'd0, mem_addr}, 32'd4);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    cyc();
    set_cpu(1, 0, 32'h10, 0);
    cpu_q.push_back(32'hDEADBEEF);
    smp();
    chk("ld_stall", {31'd0, cpu_stall}, 32'd1);
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    cyc();
    smp();
    chk("cpurd_mem_en", {31'd0, mem_en}, 32'd0);
    cyc();
    set_cpu(0, 0, 0, 0);
    smp();
    chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    cyc();

    // DMA write then read
    set_dma(1, 1, 32'h20, 32'h12345678);
    smp();
    chk("dw_gnt", {31'd0, dma_gnt}, 32'd1);
    chk("dw_mem_addr", {24'd0, mem_addr}, 32'd8);
    cyc();
    set_dma(1, 0, 32'h20, 0);
    dma_q.push_back(32'h12345678);
    smp();
    chk("dr_gnt", {31'd0, dma_gnt}, 32'd1);
    cyc();
    set_dma(0, 0, 0, 0);
    cyc();
    smp();
    chk("dma_rdata_hold", dma_rdata, 32'h12345678);
    cyc();

    // Starvation: CPU stores every cycle against a constant DMA write request
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_cpu(1, 1, 32'h100 + 4 * i, i);
      set_dma(1, 1, 32'h80, 32'hA5A5A5A5);
      exp_dma = (cnt == 4);
      cnt = exp_dma ? 0 : cnt + 1;
      smp();
      chk($sformatf("starve_gnt_%0d", i), {31'd0, dma_gnt}, {31'd0, exp_dma});
      chk($sformatf("starve_stall_%0d", i), {31'd0, cpu_stall}, {31'd0, exp_dma});
      cyc();
    end
    set_cpu(0, 0, 0, 0); set_dma(0, 0, 0, 0);
    cyc();

    // Simultaneous CPU load and DMA read below threshold
    set_cpu(1, 0, 32'h10, 0);
    set_dma(1, 0, 32'h20, 0);
    cpu_q.push_back(32'hDEADBEEF);
    smp();
    chk("sim_gnt_a", {31'd0, dma_gnt}, 32'd0);
    chk("sim_stall_a", {31'd0, cpu_stall}, 32'd1);
    chk("sim_addr_a", {24'd0, mem_addr}, 32'd4);
    cyc();
    smp();
    chk("sim_gnt_b", {31'd0, dma_gnt}, 32'd0);
    cyc();
    set_cpu(0, 0, 0, 0);
    dma_q.push_back(32'h12345678);
    smp();
    chk("sim_gnt_c", {31'd0, dma_gnt}, 32'd1);
    cyc();
    set_dma(0, 0, 0, 0);
    cyc();

    // Address wrap
    set_cpu(1, 1, 32'h400, 32'hCAFEF00D);
    smp();
    chk("wrap_st_addr", {24'd0, mem_addr}, 32'd0);
    cyc();
    set_cpu(1, 0, 32'h403, 0);
    cpu_q.push_back(32'hCAFEF00D);
    smp();
    chk("wrap_ld_addr", {24'd0, mem_addr}, 32'd0);
    cyc();
    cyc();
    set_cpu(0, 0, 0, 0);
    cyc();

    // Reset during the DMA_RD cycle
    set_dma(1, 0, 32'h20, 0);
    smp();
    chk("rr_gnt", {31'd0, dma_gnt}, 32'd1);
    cyc();
    set_dma(0, 0, 0, 0);
    set_cpu(1, 1, 32'h44, 32'h77);
    rst = 1'b0;
    smp();
    chk("rr_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("rr_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rr_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rr_wdata", mem_wdata, 32'd0);
    chk("rr_cpu_rdata", cpu_rdata, 32'd0);
    chk("rr_dma_rdata", dma_rdata, 32'd0);
    cyc();
    rst = 1'b1;
    smp();
    chk("post_rst_en", {31'd0, mem_en}, 32'd1);
    chk("post_rst_addr", {24'd0, mem_addr}, 32'd17);
    chk("post_rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
    cyc();
    set_cpu(0, 0, 0, 0);
    set_dma(1, 1, 32'h8, 32'h5);
    smp();
    chk("post_rst_dgnt", {31'd0, dma_gnt}, 32'd1);
    cyc();
    set_dma(0, 0, 0, 0);
    cyc(); cyc();

    chk("cpu_q_empty", cpu_q.size(), 32'd0);
    chk("dma_q_empty", dma_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
